// File: rtl/truth_table_scanner.sv
// Purpose: sweeps all 2**N_VARS inputs of a function, captures its truth table, then streams its term indices.
// Latency: sweep takes 2**N_VARS*(SETTLE+1) cycles after start; EMIT spends one cycle per row, plus stalls.
// Backpressure: term_idx/term_last are held while term_valid & !term_ready; a sweep does not wait on the consumer.
// Build option SOP_OUTPUT_EN: when defined, terms are minterms (f=1); otherwise they are maxterms (f=0).
module truth_table_scanner #(
    parameter int N_VARS = 3,
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic [N_VARS-1:0]        vars_out,
    input  logic                     f_in,
    output logic [(1<<N_VARS)-1:0]   table_out,
    output logic                     table_valid,
    output logic                     term_valid,
    input  logic                     term_ready,
    output logic [N_VARS-1:0]        term_idx,
    output logic                     term_last,
    output logic                     none,
    output logic                     done
);

    localparam int                DEPTH       = 1 << N_VARS;
    localparam logic [N_VARS-1:0] ROW_MAX     = '1;
    localparam logic [3:0]        SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         settle_cnt;
    logic [N_VARS-1:0]  ptr;
    logic [DEPTH-1:0]   term_mask;
    logic               term_here;
    logic               term_above;
    logic               no_terms;
    logic               settled;

    // Rows that count as terms in the selected output form.
    always_comb begin
`ifdef SOP_OUTPUT_EN
        term_mask = table_out;
`else
        term_mask = ~table_out;
`endif
    end

    assign term_here  = term_mask[ptr];
    // Lookahead: any term strictly above the current pointer.
    assign term_above = ((term_mask >> ptr) >> 1) != '0;
    assign no_terms   = (term_mask == '0);
    assign settled    = (settle_cnt == SETTLE_LAST);

    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign term_valid = (state == S_EMIT) && term_here;
    assign term_last  = term_valid && !term_above;
    assign term_idx   = ptr;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_DRIVE;
            S_DRIVE:  if (settled) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = (vars_out == ROW_MAX) ? S_EMIT : S_DRIVE;
            S_EMIT: begin
                if (no_terms) begin
                    state_nxt = S_DONE;
                end else if (term_valid) begin
                    if (term_ready && (term_last || ptr == ROW_MAX)) state_nxt = S_DONE;
                end else if (ptr == ROW_MAX) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Sweep, capture and emit datapath; results are retained after DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vars_out    <= '0;
            table_out   <= '0;
            table_valid <= 1'b0;
            none        <= 1'b0;
            settle_cnt  <= '0;
            ptr         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        vars_out    <= '0;
                        table_out   <= '0;
                        table_valid <= 1'b0;
                        none        <= 1'b0;
                        settle_cnt  <= '0;
                        ptr         <= '0;
                    end
                end
                S_DRIVE: begin
                    settle_cnt <= settled ? 4'd0 : settle_cnt + 4'd1;
                end
                S_SAMPLE: begin
                    table_out[vars_out] <= f_in;
                    if (vars_out == ROW_MAX) begin
                        table_valid <= 1'b1;
                        ptr         <= '0;
                    end else begin
                        vars_out <= vars_out + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (no_terms) begin
                        none <= 1'b1;
                    end else if ((!term_valid || (term_ready && !term_last)) && ptr != ROW_MAX) begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;

    localparam int N_VARS = 3;
    localparam int SETTLE = 1;
    localparam int DEPTH  = 1 << N_VARS;
`ifdef SOP_OUTPUT_EN
    localparam bit TERM_VAL = 1'b1;
`else
    localparam bit TERM_VAL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              term_ready = 1'b0;
    logic              f_in;
    logic              busy;
    logic [N_VARS-1:0] vars_out;
    logic [DEPTH-1:0]  table_out;
    logic              table_valid;
    logic              term_valid;
    logic [N_VARS-1:0] term_idx;
    logic              term_last;
    logic              none;
    logic              done;

    logic [DEPTH-1:0]  cur_tbl = '0;
    logic [DEPTH-1:0]  tbl_alt;
    int                total = 0;
    int                bad = 0;

    truth_table_scanner #(.N_VARS(N_VARS), .SETTLE(SETTLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .vars_out    (vars_out),
        .f_in        (f_in),
        .table_out   (table_out),
        .table_valid (table_valid),
        .term_valid  (term_valid),
        .term_ready  (term_ready),
        .term_idx    (term_idx),
        .term_last   (term_last),
        .none        (none),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Function under test: a lookup into the current truth table.
    always_comb f_in = cur_tbl[vars_out];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_vars_out"}, vars_out, 0);
        chk({tag, "_table_out"}, table_out, 0);
        chk({tag, "_table_valid"}, table_valid, 0);
        chk({tag, "_term_valid"}, term_valid, 0);
        chk({tag, "_term_idx"}, term_idx, 0);
        chk({tag, "_term_last"}, term_last, 0);
        chk({tag, "_none"}, none, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // ready_mode: 0 random, 1 always ready, 2 ready except 3 stall cycles on term 3.
    task automatic run_scan(input logic [DEPTH-1:0] tbl, input int ready_mode);
        int  q[$];
        int  n;
        int  k;
        int  cyc;
        int  stall_left;
        bit  got_last;
        bit  prev_stall;
        q = {};
        for (int i = 0; i < DEPTH; i++) begin
            if (tbl[i] == TERM_VAL) q.push_back(i);
        end
        cur_tbl = tbl;
        term_ready = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("table_valid_cleared", table_valid, 0);
        n = 0;
        while (!table_valid && n < 200) begin
            start = (n == 5);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        chk("sweep_latency", n, DEPTH * (SETTLE + 1));
        chk("table_out", table_out, tbl);
        chk("vars_out_final", vars_out, DEPTH - 1);

        k = 0;
        cyc = 0;
        stall_left = 3;
        got_last = 0;
        prev_stall = 0;
        if (q.size() == 0) begin
            chk("none_no_valid_emit", term_valid, 0);
            @(posedge clk); #1;
        end else begin
            while (!got_last && cyc < 200) begin
                case (ready_mode)
                    0:       term_ready = 1'($urandom_range(0, 1));
                    1:       term_ready = 1'b1;
                    default: term_ready = !(term_valid && term_idx == 3 && stall_left > 0);
                endcase
                if (ready_mode == 2 && !term_ready) stall_left--;
                start = (cyc == 2);
                if (prev_stall) chk("valid_held", term_valid, 1);
                if (term_valid) begin
                    if (k < q.size()) begin
                        chk("term_idx", term_idx, q[k]);
                        chk("term_last", term_last, k == q.size() - 1);
                        if (term_ready) begin
                            k++;
                            if (term_last) got_last = 1;
                        end
                    end else begin
                        chk("extra_term", term_valid, 0);
                    end
                end
                prev_stall = term_valid && !term_ready;
                @(posedge clk); #1;
                cyc++;
            end
            chk("accepted_count", k, q.size());
            if (ready_mode == 2) chk("stall_consumed", stall_left, 0);
        end
        term_ready = 1'b0;
        start = 1'b0;
        chk("done_pulse", done, 1);
        chk("none_flag", none, q.size() == 0);
        chk("done_no_valid", term_valid, 0);
        @(posedge clk); #1;
        chk("done_cleared", done, 0);
        chk("idle_not_busy", busy, 0);
        chk("table_valid_kept", table_valid, 1);
        chk("table_kept", table_out, tbl);
        chk("none_kept", none, q.size() == 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < DEPTH; i++) tbl_alt[i] = ~(i % 2 == 1);

        // Reset state
        rst_n = 1'b0;
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // a = ~z, always ready
        run_scan(tbl_alt, 1);
        // Same function with a 3-cycle stall on term 3
        run_scan(tbl_alt, 2);
        // Constant 1 and constant 0
        run_scan('1, 0);
        run_scan('0, 1);

        // Reset during EMIT after the first accepted term
        cur_tbl = tbl_alt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        term_ready = 1'b1;
        n = 0;
        while (!(term_valid && term_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_first_term", term_valid, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midscan_reset");
        term_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(tbl_alt, 0);

        // Random functions with random backpressure
        for (int t = 0; t < 6; t++) begin
            run_scan(DEPTH'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
